// File: rtl/uart_pkg.sv
// uart_pkg: FSM states and parity-type constants shared by the UART TX arbiter.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_END} arb_state_t;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: round-robin pick of the first active request at or after i_ptr.
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_onehot,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_any
);
    localparam int IW = $clog2(NUM_REQ);

    always_comb begin
        int j;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        j        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(i_ptr) + k;
            j = (j >= NUM_REQ) ? j - NUM_REQ : j;
            if (!o_any && i_req[j]) begin
                o_any       = 1'b1;
                o_onehot[j] = 1'b1;
                o_idx       = IW'(j);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to abandon frames whose TX_BUSY never rises.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]            i_req_par_en,
    input  logic [NUM_REQ-1:0]            i_req_par_type,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [DATA_WIDTH-1:0]         o_tx_p_data,
    output logic                          o_tx_par_enable,
    output logic                          o_tx_par_type,
    output logic                          o_tx_data_valid,
    input  logic                          i_tx_busy,
    output logic                          o_done,
    output logic [$clog2(NUM_REQ)-1:0]    o_owner,
    output logic                          o_err
);
    localparam int IW = $clog2(NUM_REQ);

    arb_state_t              r_state;
    logic [IW-1:0]           r_ptr;
    logic [IW-1:0]           r_owner;
    logic [NUM_REQ-1:0]      r_gnt;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_par_en;
    logic                    r_par_type;
    logic                    r_valid;
    logic                    r_done;
    logic [NUM_REQ-1:0]      w_onehot;
    logic [IW-1:0]           w_idx;
    logic                    w_any;
    logic [IW-1:0]           w_next_ptr;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    assign w_next_ptr = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_gnt      <= '0;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt      <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
            case (r_state)
                IDLE: if (w_any && !i_tx_busy) begin
                    r_gnt      <= w_onehot;
                    r_owner    <= w_idx;
                    r_data     <= i_req_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
                    r_par_en   <= i_req_par_en[w_idx];
                    r_par_type <= i_req_par_type[w_idx];
                    r_state    <= LAUNCH;
                end
                LAUNCH: begin
                    r_valid <= 1'b1;
                    r_state <= WAIT_START;
`ifdef UART_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                WAIT_START: begin
                    if (i_tx_busy) r_state <= WAIT_END;
`ifdef UART_ARB_TIMEOUT_EN
                    // Timeout lands exactly TIMEOUT_CYC cycles after the launch pulse.
                    else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        r_err   <= 1'b1;
                        r_ptr   <= w_next_ptr;
                        r_state <= IDLE;
                    end else r_cnt <= r_cnt + 1'b1;
`endif
                end
                WAIT_END: if (!i_tx_busy) begin
                    r_done  <= 1'b1;
                    r_ptr   <= w_next_ptr;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_gnt           = r_gnt;
    assign o_owner         = r_owner;
    assign o_tx_p_data     = r_data;
    assign o_tx_par_enable = r_par_en;
    assign o_tx_par_type   = r_par_type;
    assign o_tx_data_valid = r_valid;
    assign o_done          = r_done;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of grant order, launch timing, reset and timeout behaviour.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  par_en = '0;
    logic [3:0]  par_type = '0;
    logic [3:0]  gnt;
    logic [7:0]  tx_data;
    logic        tx_par_en;
    logic        tx_par_type;
    logic        tx_valid;
    logic        tx_busy;
    logic        done;
    logic [1:0]  owner;
    logic        err;
    logic        model_on = 1'b0;
    logic        m_busy = 1'b0;
    logic        man_busy = 1'b0;
    int          total = 0;
    int          bad = 0;

    assign tx_busy = model_on ? m_busy : man_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT_CYC(16)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req           (req),
        .i_req_data      (req_data),
        .i_req_par_en    (par_en),
        .i_req_par_type  (par_type),
        .o_gnt           (gnt),
        .o_tx_p_data     (tx_data),
        .o_tx_par_enable (tx_par_en),
        .o_tx_par_type   (tx_par_type),
        .o_tx_data_valid (tx_valid),
        .i_tx_busy       (tx_busy),
        .o_done          (done),
        .o_owner         (owner),
        .o_err           (err)
    );

    // Transmitter model: busy for 11 cycles after each launch pulse.
    initial begin
        int bcnt;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (model_on) begin
                if (bcnt > 0) begin
                    bcnt--;
                    if (bcnt == 0) m_busy = 1'b0;
                end else if (tx_valid) begin
                    m_busy = 1'b1;
                    bcnt = 11;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int ng;
        logic inflight;
        ng = 0;
        inflight = 1'b0;
        tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_valid", 32'(tx_valid), 0);
        chk("rst_done_err", {30'd0, done, err}, 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_data", {22'd0, tx_par_en, tx_par_type, tx_data}, 0);
        rst_n = 1'b1;
        tick();

        // Single requester 2 with odd parity
        req_data = 32'h00A5_0000;
        par_en   = 4'b0100;
        par_type = 4'b0100;
        req      = 4'b0100;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h4);
        chk("t1_owner", 32'(owner), 2);
        chk("t1_valid_early", 32'(tx_valid), 0);
        req = 4'b0000;
        tick();
        chk("t1_valid", 32'(tx_valid), 1);
        chk("t1_data", 32'(tx_data), 32'hA5);
        chk("t1_par", {30'd0, tx_par_en, tx_par_type}, 3);
        chk("t1_gnt_off", 32'(gnt), 0);
        tick();
        chk("t1_valid_once", 32'(tx_valid), 0);
        man_busy = 1'b1;
        tick();
        tick();
        chk("t1_no_done", 32'(done), 0);
        man_busy = 1'b0;
        tick();
        chk("t1_done", 32'(done), 1);
        tick();
        chk("t1_done_once", 32'(done), 0);
        chk("t1_data_hold", 32'(tx_data), 32'hA5);

        // All requesters held: rotation 0,1,2,3,0 with no overlapping frames
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        model_on = 1'b1;
        req = 4'b1111;
        for (int c = 0; c < 400 && ng < 5; c++) begin
            tick();
            if (done) inflight = 1'b0;
            if (gnt != 4'b0000) begin
                chk("t2_overlap", 32'(inflight), 0);
                chk("t2_order", 32'(gnt), 32'(1 << (ng % 4)));
                inflight = 1'b1;
                ng++;
            end
        end
        chk("t2_count", 32'(ng), 5);
        req = 4'b0000;
        for (int c = 0; c < 20; c++) tick();
        model_on = 1'b0;

        // Busy in IDLE blocks grants; short REQ pulse outside IDLE is ignored
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_data = 32'h3C00_A511;
        par_en   = 4'b0000;
        par_type = 4'b0000;
        man_busy = 1'b1;
        req = 4'b1001;
        tick();
        tick();
        chk("t3_blocked", 32'(gnt), 0);
        man_busy = 1'b0;
        tick();
        chk("t3_gnt0", 32'(gnt), 32'h1);
        chk("t3_owner0", 32'(owner), 0);
        req = 4'b1000;
        tick();
        chk("t3_valid", 32'(tx_valid), 1);
        chk("t3_data0", 32'(tx_data), 32'h11);
        tick();
        man_busy = 1'b1;
        tick();
        req = 4'b1010;
        tick();
        req = 4'b1000;
        chk("t3_pulse_gnt", 32'(gnt), 0);
        tick();
        man_busy = 1'b0;
        tick();
        chk("t3_done", 32'(done), 1);
        chk("t3_gnt_quiet", 32'(gnt), 0);
        tick();
        chk("t3_gnt3", 32'(gnt), 32'h8);
        chk("t3_owner3", 32'(owner), 3);
        req = 4'b0000;
        tick();
        chk("t3_data3", 32'(tx_data), 32'h3C);

        // Asynchronous reset in WAIT_END
        tick();
        man_busy = 1'b1;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t4_gnt", 32'(gnt), 0);
        chk("t4_valid_done", {30'd0, tx_valid, done}, 0);
        chk("t4_owner", 32'(owner), 0);
        chk("t4_data", 32'(tx_data), 0);
        man_busy = 1'b0;
        tick();
        chk("t4_no_done", 32'(done), 0);
        rst_n = 1'b1;
        tick();
        req = 4'b1010;
        tick();
        chk("t4_gnt1", 32'(gnt), 32'h2);
        chk("t4_owner1", 32'(owner), 1);
        req = 4'b0011;
        tick();
        chk("t5_valid", 32'(tx_valid), 1);

        // TX_BUSY never rises after launch
`ifdef UART_ARB_TIMEOUT_EN
        for (int c = 1; c < 16; c++) begin
            tick();
            chk("t5_err_early", 32'(err), 0);
        end
        tick();
        chk("t5_err", 32'(err), 1);
        chk("t5_no_done", 32'(done), 0);
        tick();
        chk("t5_err_once", 32'(err), 0);
        chk("t5_ptr_adv", 32'(gnt), 32'h1);
`else
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk("t5_err_zero", 32'(err), 0);
            chk("t5_stuck", 32'(gnt), 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
